seven_seg_mux: RTL and testbench

Parametrised multiplexed seven-segment display driver for NUM_DIGITS common-anode hex digits. It adds decimal points, leading-zero blanking, 16-level PWM brightness and a load/ready handshake. New values are double-buffered and applied only at frame boundaries, so a digit is never updated mid-scan. It sits between the datapath and the board display pins and replaces the fixed 4-digit, free-running scanner.

---
 rtl/seven_seg_mux_if.sv | 13 +
 rtl/seven_seg_mux.sv | 141 ++++++++++++++
 tb/tb_seven_seg_mux.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_mux_if.sv
// rtl/seven_seg_mux_if.sv - load/ready update port between the datapath and the display driver
interface seven_seg_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_en;
    logic                    load;
    logic                    ready;

    modport master (output data_in, output dp_in, output blank_en, output load, input ready);
    modport slave  (input data_in, input dp_in, input blank_en, input load, output ready);
endinterface

// File: rtl/seven_seg_mux.sv
// rtl/seven_seg_mux.sv - multiplexed common-anode hex display driver with PWM and frame-aligned updates
module seven_seg_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 10000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seven_seg_mux_if.slave        bus,
    input  logic [3:0]            bright,
    output logic [NUM_DIGITS-1:0] anodes,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_start
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    typedef enum logic {ST_READY, ST_PENDING} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic [IW-1:0]         idx_q;
    logic [3:0]            bright_q;
    logic [DW-1:0]         pend_data_q, sh_data_q;
    logic [NUM_DIGITS-1:0] pend_dp_q, sh_dp_q;
    logic                  pend_blank_q, sh_blank_q;
    logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
    logic [6:0]            seg_q, seg_dec;
    logic                  dp_q, fs_q;

    logic                  tick, boundary, accept, upper_zero, lit;
    logic [NUM_DIGITS-1:0] blank;
    logic [3:0]            nib, bright_eff;
    logic [20:0]           duty;

    assign tick      = (cnt_q == CW'(CLK_DIV - 1));
    assign boundary  = tick && (idx_q == IW'(NUM_DIGITS - 1));
    assign accept    = bus.load && (state_q == ST_READY);
    assign bus.ready = (state_q == ST_READY);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_READY:   if (accept)   state_d = ST_PENDING;
            ST_PENDING: if (boundary) state_d = ST_READY;
            default:    state_d = ST_READY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_READY;
        else        state_q <= state_d;
    end

    // A digit blanks only while every nibble from the top down to it is zero.
    always_comb begin
        upper_zero = 1'b1;
        blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (sh_data_q[4*i +: 4] == 4'h0);
            blank[i]   = sh_blank_q & upper_zero & ~sh_dp_q[i];
        end
    end

    assign nib = sh_data_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        seg_dec = 7'b1111111;
        case (nib)
            4'h0: seg_dec = 7'b0000001;
            4'h1: seg_dec = 7'b1001111;
            4'h2: seg_dec = 7'b0010010;
            4'h3: seg_dec = 7'b0000110;
            4'h4: seg_dec = 7'b1001100;
            4'h5: seg_dec = 7'b0100100;
            4'h6: seg_dec = 7'b0100000;
            4'h7: seg_dec = 7'b0001111;
            4'h8: seg_dec = 7'b0000000;
            4'h9: seg_dec = 7'b0001100;
            4'hA: seg_dec = 7'b0001000;
            4'hB: seg_dec = 7'b1100000;
            4'hC: seg_dec = 7'b0110001;
            4'hD: seg_dec = 7'b1000010;
            4'hE: seg_dec = 7'b0110000;
            4'hF: seg_dec = 7'b0111000;
            default: seg_dec = 7'b1111111;
        endcase
    end

    // The slot's first cycle uses the live brightness so the latch adds no lag.
    assign bright_eff = (cnt_q == '0) ? bright : bright_q;
    assign duty       = ((21'(bright_eff) + 21'd1) * 21'(CLK_DIV)) >> 4;
    assign lit        = (21'(cnt_q) < duty);

    always_comb begin
        anodes_d = '1;
        if (!blank[idx_q] && lit) anodes_d[idx_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            bright_q     <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= 1'b0;
            sh_data_q    <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= 1'b0;
            anodes_q     <= '1;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
            fs_q         <= 1'b0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
            if (tick) idx_q <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
            if (cnt_q == '0) bright_q <= bright;
            if (accept) begin
                pend_data_q  <= bus.data_in;
                pend_dp_q    <= bus.dp_in;
                pend_blank_q <= bus.blank_en;
            end
            if (boundary && state_q == ST_PENDING) begin
                sh_data_q  <= pend_data_q;
                sh_dp_q    <= pend_dp_q;
                sh_blank_q <= pend_blank_q;
            end
            anodes_q <= anodes_d;
            seg_q    <= blank[idx_q] ? 7'b1111111 : seg_dec;
            dp_q     <= blank[idx_q] | ~sh_dp_q[idx_q];
            fs_q     <= (idx_q == '0) && (cnt_q == '0);
        end
    end

    assign anodes      = anodes_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_seven_seg_mux.sv
// tb/tb_seven_seg_mux.sv - scoreboard bench for seven_seg_mux with 4 digits and 16-cycle slots
module tb_seven_seg_mux;
    localparam int ND = 4;
    localparam int CD = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    bright;
    logic [ND-1:0] anodes;
    logic [6:0]    seg;
    logic          dp, frame_start;

    seven_seg_mux_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_mux #(.NUM_DIGITS(ND), .CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .bright(bright),
        .anodes(anodes), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    typedef struct {
        int         digit;
        logic [6:0] seg;
        logic       dp;
        int         on;
        logic       fs;
    } slot_t;
    slot_t exp_q[$];

    logic [15:0] sh_d, pd_d;
    logic [3:0]  sh_p, pd_p;
    logic        sh_b, pd_b, rdy_m;

    task automatic push_frame();
        slot_t e;
        logic  blk;
        for (int d = 0; d < ND; d++) begin
            blk     = sh_b && (d >= 1) && ((sh_d >> (4 * d)) == 16'h0) && !sh_p[d];
            e.digit = d;
            e.seg   = blk ? 7'b1111111 : seg_tab[sh_d[4*d +: 4]];
            e.dp    = blk ? 1'b1 : ~sh_p[d];
            e.on    = blk ? 0 : (int'(bright) + 1) * CD / 16;
            e.fs    = (d == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_rst(input string t);
        check({t, "_anodes"}, anodes, 4'hF);
        check({t, "_seg"}, seg, 7'b1111111);
        check({t, "_dp"}, dp, 1'b1);
        check({t, "_fs"}, frame_start, 1'b0);
        check({t, "_ready"}, bus.ready, 1'b1);
    endtask

    // One 64-cycle frame starting at the negedge just before a cnt==0 edge.
    task automatic run_frame(input int la, input logic [15:0] ld, input logic [3:0] lp,
                             input logic lb, input int ia);
        int         on_c, oth, segv, dpv, fsc, d;
        logic [6:0] seg0;
        logic       dp0, fs0, next_rdy;
        slot_t      e;
        on_c = 0; oth = 0; segv = 0; dpv = 0; fsc = 0;
        seg0 = '0; dp0 = 1'b0; fs0 = 1'b0;
        push_frame();
        for (int c = 0; c < 64; c++) begin
            d = c / 16;
            if (c == la) begin
                bus.data_in = ld; bus.dp_in = lp; bus.blank_en = lb; bus.load = 1'b1;
            end else if (c == ia) begin
                bus.data_in = 16'hFFFF; bus.dp_in = 4'hF; bus.blank_en = 1'b0; bus.load = 1'b1;
            end
            next_rdy = rdy_m;
            if (c == 63 && !rdy_m) begin
                sh_d = pd_d; sh_p = pd_p; sh_b = pd_b; next_rdy = 1'b1;
            end
            if (bus.load && rdy_m) begin
                pd_d = bus.data_in; pd_p = bus.dp_in; pd_b = bus.blank_en; next_rdy = 1'b0;
            end
            step();
            bus.load = 1'b0;
            rdy_m = next_rdy;
            check("ready", bus.ready, rdy_m);
            if (c % 16 == 0) begin
                on_c = 0; oth = 0; segv = 0; dpv = 0; fsc = 0;
                seg0 = seg; dp0 = dp; fs0 = frame_start;
            end
            if (anodes[d] == 1'b0) on_c++;
            if (((~anodes) & ~(4'b0001 << d)) != 4'b0000) oth++;
            if (seg != seg0) segv++;
            if (dp != dp0) dpv++;
            if (frame_start) fsc++;
            if (c % 16 == 15) begin
                e = exp_q.pop_front();
                check($sformatf("an_on_d%0d", e.digit), on_c, e.on);
                check("an_other", oth, 0);
                check($sformatf("seg_d%0d", e.digit), seg0, e.seg);
                check("seg_hold", segv, 0);
                check($sformatf("dp_d%0d", e.digit), dp0, e.dp);
                check("dp_hold", dpv, 0);
                check("fs_first", fs0, e.fs);
                check("fs_count", fsc, e.fs);
            end
        end
    endtask

    initial begin
        bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.blank_en = 1'b0;
        bright = 4'd15;
        rdy_m = 1'b1;
        sh_d = '0; sh_p = '0; sh_b = 1'b0;
        pd_d = '0; pd_p = '0; pd_b = 1'b0;

        repeat (3) @(negedge clk);
        check_rst("rst");
        rst_n = 1'b1;
        #1;
        check_rst("release");
        @(negedge clk);
        check("first_slot_anodes", anodes, 4'b1110);
        check("first_slot_fs", frame_start, 1'b1);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        run_frame(-1, '0, '0, 1'b0, -1);
        run_frame(-1, '0, '0, 1'b0, -1);

        run_frame(0, 16'h12AF, 4'b0100, 1'b0, 10);
        run_frame(-1, '0, '0, 1'b0, -1);

        bright = 4'd3;
        run_frame(5, 16'h3467, 4'b0001, 1'b0, -1);
        run_frame(-1, '0, '0, 1'b0, 20);

        bright = 4'd0;
        run_frame(63, 16'h89BC, 4'b1010, 1'b0, -1);
        run_frame(-1, '0, '0, 1'b0, -1);

        bright = 4'd15;
        run_frame(0, 16'h0DE0, 4'b0000, 1'b1, -1);
        run_frame(-1, '0, '0, 1'b0, -1);

        run_frame(0, 16'h0050, 4'b0000, 1'b1, -1);
        run_frame(-1, '0, '0, 1'b0, -1);
        run_frame(0, 16'h0050, 4'b1000, 1'b1, -1);
        run_frame(-1, '0, '0, 1'b0, -1);

        bus.data_in = 16'h1234; bus.dp_in = 4'hF; bus.blank_en = 1'b0; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        check("async_pre_ready", bus.ready, 1'b0);
        repeat (19) step();
        check("async_pre_anodes", anodes, 4'b1101);
        rst_n = 1'b0;
        #1;
        check_rst("async");
        repeat (3) step();
        check_rst("hold");
        rst_n = 1'b1;
        rdy_m = 1'b1;
        sh_d = '0; sh_p = '0; sh_b = 1'b0;
        pd_d = '0; pd_p = '0; pd_b = 1'b0;
        run_frame(-1, '0, '0, 1'b0, -1);
        run_frame(-1, '0, '0, 1'b0, -1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
